// File: rtl/uart_pkg.sv
// Shared types and helpers for the byte UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit so full and empty
// fall out of pointer comparison and the level is the pointer difference.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_data,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_data,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_level
);

  localparam int unsigned AW = cnt_width(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_diff;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_diff    = r_wr_ptr - r_rd_ptr;
  assign o_level   = LW'(w_diff);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; full is judged from registered state only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/byte_uart_tx.sv
// Byte-wide UART transmitter with an input FIFO: 8 data bits LSB first,
// optional even/odd parity, one stop bit, back-to-back frames contiguous.
module byte_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PARITY       = PARITY_NONE
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int unsigned    BW        = cnt_width(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_t   r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_data;
  logic          r_tx;

  logic [7:0]    w_fifo_data;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_baud_last;
  logic          w_parity;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_valid),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign w_baud_last = (r_baud == BAUD_LAST);
  assign w_parity    = (PARITY == PARITY_ODD) ? ~(^r_data) : ^r_data;
  // A byte leaves the FIFO when idle, or on the last stop cycle so the
  // next start bit follows with no gap.
  assign w_pop       = !w_empty &&
                       ((r_state == ST_IDLE) ||
                        ((r_state == ST_STOP) && w_baud_last));

  assign in_ready = !w_full;
  assign tx       = r_tx;
  assign busy     = (r_state != ST_IDLE) || (fifo_level != '0);

  // Frame sequencer: baud counter, bit index and registered line output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_data    <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_baud <= '0;
          r_tx   <= 1'b1;
          if (w_pop) begin
            r_data  <= w_fifo_data;
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end
        end

        ST_START: begin
          if (w_baud_last) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_data[0];
            r_state   <= ST_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        ST_DATA: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              if (PARITY != PARITY_NONE) begin
                r_tx    <= w_parity;
                r_state <= ST_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_data[r_bit_idx + 3'd1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        ST_PARITY: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_tx    <= 1'b1;
            r_state <= ST_STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        ST_STOP: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (w_pop) begin
              r_data  <= w_fifo_data;
              r_tx    <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        default: begin
          r_baud  <= '0;
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_uart_tx.sv
// Scoreboard bench for byte_uart_tx: three instances (no parity at 4 clk/bit,
// even parity at 4 clk/bit, odd parity at the 2 clk/bit minimum) each get a
// driver that queues expected bytes with their acceptance edge, and a monitor
// that checks every frame bit-cycle and its start edge against the queue.
module tb_byte_uart_tx;

  localparam int NI = 3;
  localparam int          CPB_T   [NI] = '{4, 4, 2};
  localparam int          PAR_T   [NI] = '{0, 1, 2};
  localparam logic [7:0]  FIRST_T [NI] = '{8'hA5, 8'h07, 8'h07};

  typedef struct {
    logic [7:0] b;
    int         pe;
  } ent_t;

  logic                 clk;
  int                   cyc = 0;
  logic [NI-1:0]        rst_v;
  logic [NI-1:0]        vin;
  logic [NI-1:0]        rdy;
  logic [NI-1:0]        txl;
  logic [NI-1:0]        busy;
  logic [NI-1:0][7:0]   din;
  logic [NI-1:0][2:0]   lvl;

  ent_t     q [NI][$];
  int       prev_end [NI];
  bit [NI-1:0] drv_done;
  int       checks;
  int       failures;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    byte_uart_tx #(
      .CLKS_PER_BIT (CPB_T[g]),
      .FIFO_DEPTH   (4),
      .PARITY       (PAR_T[g])
    ) u_dut (
      .clk        (clk),
      .rst        (rst_v[g]),
      .in_data    (din[g]),
      .in_valid   (vin[g]),
      .in_ready   (rdy[g]),
      .tx         (txl[g]),
      .busy       (busy[g]),
      .fifo_level (lvl[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int fl(input int i);
    return ((PAR_T[i] != 0) ? 11 : 10) * CPB_T[i];
  endfunction

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h required=%0h t=%0t", nm, i, act, exp, $time);
    end
  endtask

  // Offer one byte; expected entry records the edge number that accepts it.
  task automatic push(input int i, input logic [7:0] b, input bit chk_full);
    int   n;
    ent_t e;
    @(negedge clk);
    din[i] = b;
    vin[i] = 1'b1;
    n = 0;
    while (!rdy[i] && n < 2000) begin
      if (chk_full) chk("held_level", i, 32'(lvl[i]), 4);
      @(negedge clk);
      n++;
    end
    if (!rdy[i]) begin
      chk("push_timeout", i, 32'(n), 0);
      vin[i] = 1'b0;
      return;
    end
    if (chk_full) chk("level_before_accept", i, 32'(lvl[i]), 3);
    e.b  = b;
    e.pe = cyc + 1;
    q[i].push_back(e);
    @(posedge clk);
    #1 vin[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy[i] || q[i].size() != 0) && n < 200 * fl(i)) begin
      @(negedge clk);
      n++;
    end
    chk("drain", i, 32'(busy[i] || (q[i].size() != 0)), 0);
  endtask

  task automatic drv(input int i);
    int f;
    int gap;
    f = fl(i);
    rst_v[i] = 1'b1;
    vin[i]   = 1'b0;
    din[i]   = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", i, 32'(txl[i]), 1);
    chk("rst_ready", i, 32'(rdy[i]), 1);
    chk("rst_busy", i, 32'(busy[i]), 0);
    chk("rst_level", i, 32'(lvl[i]), 0);
    rst_v[i] = 1'b0;

    // First byte into an idle block: latency and busy timing.
    push(i, FIRST_T[i], 1'b0);
    @(negedge clk);
    chk("tx_before_start", i, 32'(txl[i]), 1);
    chk("level_after_push", i, 32'(lvl[i]), 1);
    @(negedge clk);
    chk("start_latency", i, 32'(txl[i]), 0);
    chk("level_after_pop", i, 32'(lvl[i]), 0);
    repeat (f - 1) @(negedge clk);
    chk("busy_last_stop", i, 32'(busy[i]), 1);
    @(negedge clk);
    chk("busy_after_frame", i, 32'(busy[i]), 0);
    chk("tx_idle", i, 32'(txl[i]), 1);

    // All-zero then all-one data, back to back.
    push(i, 8'h00, 1'b0);
    push(i, 8'hFF, 1'b0);
    drain(i);

    // Five-byte burst fills the FIFO, then 0x3C waits on in_ready.
    for (int k = 0; k < 5; k++) push(i, 8'($urandom), 1'b0);
    @(negedge clk);
    chk("burst_ready", i, 32'(rdy[i]), 0);
    chk("burst_level", i, 32'(lvl[i]), 4);
    push(i, 8'h3C, 1'b1);
    drain(i);

    // Random bytes with random gaps, sometimes back to back.
    for (int k = 0; k < 16; k++) begin
      push(i, 8'($urandom), 1'b0);
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, f + 2));
      repeat (gap) @(negedge clk);
    end
    drain(i);

    // Reset in the middle of the data bits with two bytes queued.
    push(i, 8'h00, 1'b0);
    push(i, 8'($urandom), 1'b0);
    push(i, 8'($urandom), 1'b0);
    repeat (4 * CPB_T[i]) @(negedge clk);
    chk("tx_mid_data", i, 32'(txl[i]), 0);
    chk("level_mid_data", i, 32'(lvl[i]), 2);
    #2 rst_v[i] = 1'b1;
    #1;
    chk("async_rst_tx", i, 32'(txl[i]), 1);
    chk("async_rst_level", i, 32'(lvl[i]), 0);
    chk("async_rst_busy", i, 32'(busy[i]), 0);
    chk("async_rst_ready", i, 32'(rdy[i]), 1);
    q[i].delete();
    prev_end[i] = 0;
    repeat (2) @(negedge clk);
    rst_v[i] = 1'b0;
    push(i, 8'($urandom), 1'b0);
    push(i, 8'($urandom), 1'b0);
    drain(i);
    drv_done[i] = 1'b1;
  endtask

  // A frame should start one edge after acceptance, but never before the
  // previous frame's stop bit has run its full length.
  task automatic mon(input int i);
    ent_t        e;
    int          st;
    int          xs;
    int          nb;
    int          errs;
    int          cpb;
    bit          ab;
    logic [10:0] bits;
    cpb = CPB_T[i];
    nb  = (PAR_T[i] != 0) ? 11 : 10;
    while (!drv_done[i]) begin
      @(negedge clk);
      if (!rst_v[i] && txl[i] == 1'b0) begin
        st = cyc;
        chk("frame_expected", i, 32'(q[i].size() != 0), 1);
        if (q[i].size() != 0) begin
          e = q[i].pop_front();
        end else begin
          e.b  = '0;
          e.pe = st - 1;
        end
        xs = (e.pe + 1 > prev_end[i]) ? e.pe + 1 : prev_end[i];
        chk("frame_start_edge", i, 32'(st), 32'(xs));
        prev_end[i] = st + fl(i);
        bits    = '1;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[k+1] = e.b[k];
        if (PAR_T[i] == 1) bits[9] = ^e.b;
        if (PAR_T[i] == 2) bits[9] = ~(^e.b);
        errs = 0;
        ab   = 1'b0;
        for (int c = 0; c < nb * cpb; c++) begin
          if (c > 0) @(negedge clk);
          if (rst_v[i]) begin
            ab = 1'b1;
            break;
          end
          if (txl[i] !== bits[c / cpb]) errs++;
        end
        if (!ab) begin
          checks++;
          if (errs != 0) begin
            failures++;
            $display("FAIL frame_bits[%0d] byte=%02h bad_cycles=%0d required=0", i, e.b, errs);
          end
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drv_done = '0;
    for (int k = 0; k < NI; k++) prev_end[k] = 0;
    fork
      drv(0);
      drv(1);
      drv(2);
      mon(0);
      mon(1);
      mon(2);
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=completion checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/byte_uart_tx.md
Name: byte_uart_tx

Overview:
Serialises the 8-bit result bytes produced by the registered counter/increment stage into an asynchronous UART frame on one output pin. It sits directly downstream of that stage and accepts bytes over a valid/ready handshake. A small FIFO absorbs bursts, so the upstream stage can post several results back-to-back while a frame is still on the wire.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit; minimum 2 (434 = 50 MHz / 115200).
FIFO_DEPTH, 4, byte FIFO entries; power of two, minimum 2.
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  8  byte to transmit
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  FIFO can accept; equals !full
tx  output  1  UART line, idle high, registered
busy  output  1  FIFO non-empty or frame in progress
fifo_level  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset values: tx=1, in_ready=1, busy=0, fifo_level=0. FIFO is emptied and the FSM goes to IDLE.
- Reset while a frame is in progress: tx returns high immediately (asynchronous). The partial frame and all queued bytes are discarded.
- Push: a byte is accepted on a rising edge when in_valid && in_ready. While in_valid=1 and in_ready=0, in_data is ignored and the upstream stage holds it.
- in_ready is !full from registered state. A pop in the same cycle does not enable a push when the FIFO is full.
- Simultaneous push and pop when the FIFO is neither full nor empty: both happen and fifo_level is unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when the FIFO is non-empty. On that edge the FSM pops the head byte into the shift register and sets tx=0.
- Latency: tx falls on the first clk edge after the edge that accepted a byte into an empty, idle block.
- Bit timing: baud counter runs 0..CLKS_PER_BIT-1. Each bit holds tx for exactly CLKS_PER_BIT cycles.
- START: tx=0, then DATA.
- DATA: 8 bits, LSB first, with a bit index 0..7. After bit 7 the FSM goes to PARITY if PARITY!=0, else STOP.
- PARITY: tx = XOR of the data bits (even) or its inverse (odd).
- STOP: tx=1 for one bit time.
- On the last cycle of STOP: if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Frame length: 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- Back-to-back frames are contiguous.
- busy = (state != IDLE) || (fifo_level != 0).
- FIFO pointers carry one extra wrap bit. full/empty are derived from pointer equality and the wrap bit. fifo_level is the pointer difference.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - PARITY_NONE/EVEN/ODD constants
  - function computing counter widths
- One sub-module, sync_fifo: parameterised width and depth, with push, pop, full, empty and level.
- FSM, baud counter and shift register stay in byte_uart_tx.

Test Plan:
- Reset, then push 0xA5 with CLKS_PER_BIT=4, PARITY=0 -> tx low starting one edge after acceptance. LSB-first bits 1,0,1,0,0,1,0,1 follow, then stop=1; each bit is 4 cycles and the frame is 40 cycles. busy drops after the stop bit.
- PARITY=1, byte 0x07 -> parity bit 1. PARITY=2, byte 0x07 -> parity bit 0. The frame is 44 cycles at CLKS_PER_BIT=4.
- Push 5 bytes on consecutive cycles, FIFO_DEPTH=4 -> in_ready deasserts after the 4th stored byte (3 still queued after the first pop). All 5 bytes are transmitted in order, contiguous with no idle cycles between stop and start.
- Fill the FIFO to 4 while in_valid is held with 0x3C -> in_ready=0, fifo_level stays at 4 until the next pop. 0x3C is accepted on the edge after the pop and appears as the last transmitted byte.
- Assert rst mid-DATA of a frame with 2 bytes queued -> tx=1 immediately, fifo_level=0, busy=0. A new byte after release is framed correctly from its start bit.
- Push 0x00 then 0xFF with CLKS_PER_BIT=2 (minimum) -> exact 2-cycle bit widths, correct framing, no glitch on tx at frame boundaries.
